// File: rtl/key_entry_if.sv
// key_entry_if: key-pulse inputs and commit handshake between the PS/2 key
// decoder / consumer logic (master side) and key_entry_buffer (slave side).
interface key_entry_if #(
    parameter int DIGITS = 4,
    parameter int CW     = $clog2(DIGITS + 1)
);
    logic [15:0]         key_hex;
    logic                key_enter;
    logic                key_correct;
    logic                key_back;
    logic                key_yes;
    logic                key_no;
    logic                hex_mode;
    logic                commit_ready;
    logic [4*DIGITS-1:0] entry_value;
    logic [CW-1:0]       entry_count;
    logic                confirm_pending;
    logic                commit_valid;
    logic [4*DIGITS-1:0] commit_value;
    logic                key_reject;

    modport slave (
        input  key_hex, key_enter, key_correct, key_back, key_yes, key_no,
        input  hex_mode, commit_ready,
        output entry_value, entry_count, confirm_pending,
        output commit_valid, commit_value, key_reject
    );

    modport master (
        output key_hex, key_enter, key_correct, key_back, key_yes, key_no,
        output hex_mode, commit_ready,
        input  entry_value, entry_count, confirm_pending,
        input  commit_valid, commit_value, key_reject
    );
endinterface

// File: rtl/key_entry_buffer.sv
// key_entry_buffer: collects one-cycle key pulses into a right-aligned nibble
// buffer (shift-in, delete, clear) and hands the finished entry to a
// valid/ready commit port. Keys arriving while a commit is outstanding are
// dropped.
// Build option: define KEY_ENTRY_CONFIRM_EN to insert a yes/no confirmation
// step between key_enter and the commit; otherwise key_enter commits directly.
module key_entry_buffer #(
    parameter int DIGITS = 4,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input logic        clk,
    input logic        rst,
    key_entry_if.slave bus
);
    localparam int W = 4 * DIGITS;

`ifdef KEY_ENTRY_CONFIRM_EN
    typedef enum logic [1:0] {EDIT = 2'd0, CONFIRM = 2'd1, COMMIT = 2'd2} state_t;
`else
    typedef enum logic {EDIT = 1'b0, COMMIT = 1'b1} state_t;
    // key_yes/key_no have no effect without the confirmation step
    logic unused_confirm_keys;
    assign unused_confirm_keys = bus.key_yes ^ bus.key_no;
`endif

    state_t        state, state_nxt;
    logic [W-1:0]  value, value_nxt;
    logic [W-1:0]  commit_val, commit_val_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          reject, reject_nxt;
    logic [3:0]    digit;
    logic          digit_hit;

    assign digit_hit = |bus.key_hex;

    // Pick the lowest set key_hex bit when several digit keys pulse together
    always_comb begin
        digit = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (bus.key_hex[i]) digit = 4'(i);
        end
    end

    // State and datapath registers; reset clears everything including a pending commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EDIT;
            value      <= '0;
            count      <= '0;
            commit_val <= '0;
            reject     <= 1'b0;
        end else begin
            state      <= state_nxt;
            value      <= value_nxt;
            count      <= count_nxt;
            commit_val <= commit_val_nxt;
            reject     <= reject_nxt;
        end
    end

    // Next state and buffer update; one key acts per cycle in priority order
    always_comb begin
        state_nxt      = state;
        value_nxt      = value;
        count_nxt      = count;
        commit_val_nxt = commit_val;
        reject_nxt     = 1'b0;
        case (state)
            EDIT: begin
                if (bus.key_back) begin
                    value_nxt = '0;
                    count_nxt = '0;
                end else if (bus.key_correct) begin
                    if (count != '0) begin
                        value_nxt = value >> 4;
                        count_nxt = count - CW'(1);
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end else if (bus.key_enter) begin
                    if (count == '0) begin
                        reject_nxt = 1'b1;
                    end else begin
`ifdef KEY_ENTRY_CONFIRM_EN
                        state_nxt = CONFIRM;
`else
                        state_nxt      = COMMIT;
                        commit_val_nxt = value;
`endif
                    end
                end else if (digit_hit) begin
                    if (count == CW'(DIGITS)) begin
                        reject_nxt = 1'b1;
                    end else if (digit >= 4'd10 && !bus.hex_mode) begin
                        reject_nxt = 1'b1;
                    end else begin
                        // Oldest nibble falls off the top; newest lands in [3:0]
                        value_nxt = W'({value, digit});
                        count_nxt = count + CW'(1);
                    end
                end
            end
`ifdef KEY_ENTRY_CONFIRM_EN
            CONFIRM: begin
                if (bus.key_back) begin
                    value_nxt = '0;
                    count_nxt = '0;
                    state_nxt = EDIT;
                end else if (bus.key_yes) begin
                    commit_val_nxt = value;
                    state_nxt      = COMMIT;
                end else if (bus.key_no) begin
                    state_nxt = EDIT;
                end
            end
`endif
            COMMIT: begin
                // commit_valid is high throughout COMMIT, so ready alone completes the handshake
                if (bus.commit_ready) begin
                    value_nxt = '0;
                    count_nxt = '0;
                    state_nxt = EDIT;
                end
            end
            default: state_nxt = EDIT;
        endcase
    end

    // Outputs come straight from registers or decoded registered state
    always_comb begin
        bus.entry_value  = value;
        bus.entry_count  = count;
        bus.commit_value = commit_val;
        bus.key_reject   = reject;
        bus.commit_valid = (state == COMMIT);
`ifdef KEY_ENTRY_CONFIRM_EN
        bus.confirm_pending = (state == CONFIRM);
`else
        bus.confirm_pending = 1'b0;
`endif
    end
endmodule

// File: tb/tb_key_entry_buffer.sv
// Scoreboard bench for key_entry_buffer (DIGITS=4). Stimulus pushes hand-computed
// expectations; monitors compare buffer state each due cycle and commit values
// at each handshake. Confirmation-only sequences follow KEY_ENTRY_CONFIRM_EN.
module tb_key_entry_buffer;
    localparam int DIGITS = 4;

    localparam logic [4:0] BK = 5'b10000;  // back
    localparam logic [4:0] CR = 5'b01000;  // correct
    localparam logic [4:0] EN = 5'b00100;  // enter
    localparam logic [4:0] YS = 5'b00010;  // yes
    localparam logic [4:0] NO = 5'b00001;  // no
    localparam logic [4:0] NK = 5'b00000;  // no control key

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_entry_if #(.DIGITS(DIGITS)) bus ();
    key_entry_buffer #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          due;
        string       name;
        logic [15:0] val;
        int          cnt;
        logic        rej;
        logic        vld;
        logic        pend;
    } exp_t;

    exp_t        q[$];
    logic [15:0] cq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] kd(input int d);
        logic [15:0] one;
        one = 16'd1;
        return one << d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs (caller sits at a negedge) and queue the expected outputs
    task automatic step(input string nm, input logic [15:0] hx, input logic [4:0] ctl,
                        input logic rdy, input logic [15:0] ev, input int ec,
                        input logic er, input logic cv, input logic cp);
        exp_t e;
        bus.key_hex = hx;
        {bus.key_back, bus.key_correct, bus.key_enter, bus.key_yes, bus.key_no} = ctl;
        bus.commit_ready = rdy;
        e.due = cyc + 1; e.name = nm; e.val = ev; e.cnt = ec;
        e.rej = er; e.vld = cv; e.pend = cp;
        q.push_back(e);
        @(negedge clk);
        bus.key_hex = '0;
        {bus.key_back, bus.key_correct, bus.key_enter, bus.key_yes, bus.key_no} = '0;
    endtask

    // Finish the current entry; commit_valid is expected high after the last step
    task automatic do_commit(input string nm, input logic [15:0] v, input int c, input logic rdy);
        cq.push_back(v);
`ifdef KEY_ENTRY_CONFIRM_EN
        step({nm, "_enter"}, '0, EN, rdy, v, c, 1'b0, 1'b0, 1'b1);
        step({nm, "_yes"},   '0, YS, rdy, v, c, 1'b0, 1'b1, 1'b0);
`else
        step({nm, "_enter"}, '0, EN, rdy, v, c, 1'b0, 1'b1, 1'b0);
`endif
    endtask

    // Buffer-state monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk(e.name,
                    {bus.entry_value, bus.entry_count, bus.key_reject, bus.commit_valid, bus.confirm_pending},
                    {e.val, 3'(e.cnt), e.rej, e.vld, e.pend});
                if (e.vld) begin
                    if (cq.size() > 0) begin
                        chk({e.name, "_cval"}, bus.commit_value, cq[0]);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL %s_cval got=%h exp=none", e.name, bus.commit_value);
                    end
                end
            end
        end
    end

    // Commit-handshake monitor: inputs and outputs seen just before the edge
    initial begin
        logic [15:0] v;
        forever begin
            @(posedge clk);
            if (rst && bus.commit_valid && bus.commit_ready) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake got=%h exp=none", bus.commit_value);
                end else begin
                    v = cq.pop_front();
                    chk("handshake", bus.commit_value, v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.key_hex = '0;
        {bus.key_back, bus.key_correct, bus.key_enter, bus.key_yes, bus.key_no} = '0;
        bus.commit_ready = 1'b0;
        bus.hex_mode = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset", {bus.entry_value, bus.entry_count, bus.key_reject, bus.commit_valid,
                      bus.confirm_pending, bus.commit_value}, '0);
        rst = 1'b1;

        // shift-in and delete
        step("d1",    kd(1), NK, 0, 16'h0001, 1, 0, 0, 0);
        step("d2",    kd(2), NK, 0, 16'h0012, 2, 0, 0, 0);
        step("d3",    kd(3), NK, 0, 16'h0123, 3, 0, 0, 0);
        step("corr",  '0,    CR, 0, 16'h0012, 2, 0, 0, 0);
        step("back",  '0,    BK, 0, 16'h0000, 0, 0, 0, 0);
        step("corr0", '0,    CR, 0, 16'h0000, 0, 1, 0, 0);
        step("ent0",  '0,    EN, 0, 16'h0000, 0, 1, 0, 0);
        // full buffer
        step("f1",    kd(1), NK, 0, 16'h0001, 1, 0, 0, 0);
        step("f2",    kd(2), NK, 0, 16'h0012, 2, 0, 0, 0);
        step("f3",    kd(3), NK, 0, 16'h0123, 3, 0, 0, 0);
        step("f4",    kd(4), NK, 0, 16'h1234, 4, 0, 0, 0);
        step("f5",    kd(5), NK, 0, 16'h1234, 4, 1, 0, 0);
        step("fidle", '0,    NK, 0, 16'h1234, 4, 0, 0, 0);
        step("fback", '0,    BK, 0, 16'h0000, 0, 0, 0, 0);
        // decimal / hex mode
        bus.hex_mode = 1'b0;
        step("dec_c", kd(12), NK, 0, 16'h0000, 0, 1, 0, 0);
        step("dec_9", kd(9),  NK, 0, 16'h0009, 1, 0, 0, 0);
        bus.hex_mode = 1'b1;
        step("hex_c", kd(12), NK, 0, 16'h009C, 2, 0, 0, 0);
        step("hback", '0,     BK, 0, 16'h0000, 0, 0, 0, 0);
        // priority
        step("low_bit",   kd(3) | kd(5), NK,      0, 16'h0003, 1, 0, 0, 0);
        step("back_dig",  kd(2),         BK,      0, 16'h0000, 0, 0, 0, 0);
        step("p9",        kd(9),         NK,      0, 16'h0009, 1, 0, 0, 0);
        step("corr_ent",  kd(7),         CR | EN, 0, 16'h0000, 0, 0, 0, 0);
        step("yes_edit",  '0,            YS,      0, 16'h0000, 0, 0, 0, 0);
        step("no_edit",   '0,            NO,      0, 16'h0000, 0, 0, 0, 0);
        // build 42, then commit with ready held low
        step("c4", kd(4), NK, 0, 16'h0004, 1, 0, 0, 0);
        step("c2", kd(2), NK, 0, 16'h0042, 2, 0, 0, 0);
`ifdef KEY_ENTRY_CONFIRM_EN
        step("cf_enter", '0,    EN, 0, 16'h0042, 2, 0, 0, 1);
        step("cf_dig",   kd(1), NK, 0, 16'h0042, 2, 0, 0, 1);
        step("cf_corr",  '0,    CR, 0, 16'h0042, 2, 0, 0, 1);
        step("cf_no",    '0,    NO, 0, 16'h0042, 2, 0, 0, 0);
`endif
        do_commit("c42", 16'h0042, 2, 0);
        step("hold1",   '0,    NK, 0, 16'h0042, 2, 0, 1, 0);
        step("hold2",   '0,    NK, 0, 16'h0042, 2, 0, 1, 0);
        step("hold_k",  kd(1), EN, 0, 16'h0042, 2, 0, 1, 0);
        step("hs42",    '0,    NK, 1, 16'h0000, 0, 0, 0, 0);
`ifdef KEY_ENTRY_CONFIRM_EN
        step("cb5",     kd(5), NK, 0, 16'h0005, 1, 0, 0, 0);
        step("cb_ent",  '0,    EN, 0, 16'h0005, 1, 0, 0, 1);
        step("cb_back", '0,    BK, 0, 16'h0000, 0, 0, 0, 0);
`endif
        // key in the handshake cycle is dropped; the next one lands
        step("d6", kd(6), NK, 0, 16'h0006, 1, 0, 0, 0);
        do_commit("c6", 16'h0006, 1, 0);
        step("hs_drop",   kd(8), NK, 1, 16'h0000, 0, 0, 0, 0);
        step("first_key", kd(8), NK, 1, 16'h0008, 1, 0, 0, 0);
        // continuous ready gives a one-cycle valid pulse
        step("rb",    '0,    BK, 1, 16'h0000, 0, 0, 0, 0);
        step("r3",    kd(3), NK, 1, 16'h0003, 1, 0, 0, 0);
        do_commit("c3", 16'h0003, 1, 1);
        step("pulse", '0,    NK, 1, 16'h0000, 0, 0, 0, 0);
        // reset during an outstanding commit
        step("x2", kd(2), NK, 0, 16'h0002, 1, 0, 0, 0);
        do_commit("c2r", 16'h0002, 1, 0);
        rst = 1'b0;
        #1;
        chk("rst_mid", {bus.entry_value, bus.entry_count, bus.key_reject, bus.commit_valid,
                        bus.confirm_pending, bus.commit_value}, '0);
        cq.delete();
        @(negedge clk);
        rst = 1'b1;
        step("after7", kd(7), NK, 0, 16'h0007, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(q.size() + cq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
